fpu_mul_seq: RTL and testbench
==============================

# fpu_mul_seq

Multicycle IEEE-754 single-precision multiplier for the FPU path of the multicycle ARM core. It is launched by the controller's `FPUWrite` strobe and multiplies two register operands with an iterative shift-add mantissa datapath. It returns the packed result plus NZCV-style flags for the register-file writeback and flag logic, holding the result stable until the next operation completes.

## Interface

No parameters; the format is fixed at binary32.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `Start`  in  1  launch strobe; driven by the controller's `FPUWrite`; sampled only in IDLE.
- `SrcA`  in  32  operand A, binary32.
- `SrcB`  in  32  operand B, binary32.
- `Result`  out  32  product, binary32; holds its value until the next Done.
- `Flags`  out  4  {N,Z,C,V}; valid with Done and held afterwards.
- `Busy`  out  1  high in any state other than IDLE.
- `Done`  out  1  one-cycle pulse; Result and Flags update in the same cycle.

## Operation

- **States:** IDLE, MUL, NORM, DONE.
- **IDLE:**
  - On Start, register both operands, sign = sA^sB, and raw exponent = eA+eB-127 (10-bit signed).
  - Clear the 48-bit product register and the 5-bit iteration counter.
  - Next state is MUL, or DONE if a special case applies.
- **Special cases (bypass, resolved in IDLE):**
  - Exponent 0 is treated as zero, so subnormal inputs are flushed to zero.
  - Either operand NaN, or inf×0 → 0x7FC00000 (canonical NaN).
  - inf×nonzero → signed inf.
  - Zero×finite → signed zero.
- **MUL:**
  - One iteration per cycle: if multiplier bit[cnt] = 1, add mantissa A (implicit 1 included) shifted by cnt into the product.
  - Exactly 24 iterations (cnt 0..23), then go to NORM.
- **NORM:**
  - If product bit47 = 1: mantissa = bits46:24 and exponent +1.
  - Else: mantissa = bits45:23.
  - Rounding per Configuration.
  - Exponent ≥ 255 → signed inf, V = 1.
  - Exponent ≤ 0 → signed zero (flush).
  - Go to DONE.
- **DONE:**
  - Done = 1; Result and Flags are loaded.
  - Go to IDLE.
- **Flags:**
  - N = result sign bit.
  - Z = result is ±0.
  - C = 0 always.
  - V = overflow to infinity occurred.
  - NaN results report N=0, Z=0, V=0.
- Start while Busy is ignored; the in-flight operation is unaffected.

## Timing

- Reset values:
  - State = IDLE.
  - Result = 0x00000000, Flags = 0000.
  - Busy = 0, Done = 0.
  - Counter and product = 0.
- **Normal path:** Start sampled at edge t → Busy high from t. Done is high during the cycle after edge t+25 (24 MUL + 1 NORM + DONE). Busy drops at edge t+26.
- **Special-case path:** Done is high during the cycle after edge t+1.
- **Back-to-back:** Start may be asserted in the same cycle Busy falls, because IDLE samples it; minimum spacing is 26 cycles on the normal path.
- **Reset mid-operation:** at the next edge, return to IDLE. No Done pulse is produced, and Result/Flags return to 0.
- **Operand stability:** SrcA/SrcB only need to be stable at the sampling edge.

## Configuration

- `FPU_MUL_RNE_EN`: round-to-nearest-even in NORM.
  - Uses guard bit = first discarded bit and sticky = OR of the remaining discarded bits.
  - Increment when guard & (sticky | lsb).
  - A mantissa carry-out increments the exponent, and the overflow check is applied after rounding.
- Without the macro: truncation (round toward zero), with no guard/sticky logic.

## Test plan

- 0x40000000 × 0x40400000 (2×3), Start at t → Done at t+25, Result 0x40C00000, Flags 0000.
- 0xBFC00000 × 0x40000000 (-1.5×2) → Result 0xC0400000, Flags 1000.
- 0x7F800000 × 0x00000000 (inf×0) → Done at t+1, Result 0x7FC00000, Flags 0000. Also, 0x00000000 × 0x3F800000 → Done at t+1, Result 0x00000000, Flags 0100.
- 0x7F000000 × 0x7F000000 → Result 0x7F800000, Flags 0001.
- 0x3FC00001 × 0x3FC00001 → Result 0x40100002 with `FPU_MUL_RNE_EN`, 0x40100001 without it.
- Start 0x40000000 × 0x40400000, pulse reset at t+10 → Busy 0 from t+11, no Done, Result 0. A Start raised while Busy is ignored, and the second operation completes normally afterwards.

Source files
------------

// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: multicycle IEEE-754 binary32 multiplier for the FPU path.
// The mantissa product is built with a 24-step shift-add loop, one step per
// cycle, then normalised. NaN/inf/zero operands bypass the loop and are
// resolved as soon as Start is sampled.
// Compile-time option: define FPU_MUL_RNE_EN for round-to-nearest-even in
// the normalise step; the default build truncates (round toward zero).
module fpu_mul_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic [31:0] Result,
   output logic [3:0]  Flags,
   output logic        Busy,
   output logic        Done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [23:0]        ma_q, ma_d;
   logic [23:0]        mb_q, mb_d;
   logic               sign_q, sign_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [47:0]        prod_q, prod_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               special_q, special_d;
   logic [31:0]        spres_q, spres_d;
   logic [3:0]         spflags_q, spflags_d;
   logic [31:0]        result_q, result_d;
   logic [3:0]         flags_q, flags_d;
   logic               done_q, done_d;

   // Special-case decode of the live operands
   logic               sp_hit_s;
   logic [31:0]        sp_res_s;

   // Normalise/round outputs
   logic [22:0]        norm_mant_s;
   logic signed [9:0]  norm_exp_s;
   logic [22:0]        fin_mant_s;
   logic signed [9:0]  fin_exp_s;
   logic [31:0]        norm_res_s;
   logic               norm_ovf_s;
`ifdef FPU_MUL_RNE_EN
   logic               guard_s;
   logic               sticky_s;
   logic [24:0]        rnd_s;
`endif

   // {N,Z,C,V} for a packed result; NaN reports all flags clear.
   function automatic logic [3:0] mk_flags(input logic [31:0] r, input logic ovf);
      logic is_nan;
      is_nan = (r[30:23] == 8'hFF) && (r[22:0] != 23'd0);
      if (is_nan) begin
         mk_flags = 4'b0000;
      end else begin
         mk_flags = {r[31], (r[30:0] == 31'd0), 1'b0, ovf};
      end
   endfunction

   // Classify the operands for the bypass path (exponent 0 counts as zero).
   always_comb begin
      logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
      a_zero   = (SrcA[30:23] == 8'h00);
      b_zero   = (SrcB[30:23] == 8'h00);
      a_inf    = (SrcA[30:23] == 8'hFF) && (SrcA[22:0] == 23'd0);
      b_inf    = (SrcB[30:23] == 8'hFF) && (SrcB[22:0] == 23'd0);
      a_nan    = (SrcA[30:23] == 8'hFF) && (SrcA[22:0] != 23'd0);
      b_nan    = (SrcB[30:23] == 8'hFF) && (SrcB[22:0] != 23'd0);
      sgn      = SrcA[31] ^ SrcB[31];
      sp_hit_s = 1'b1;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         sp_res_s = 32'h7FC0_0000;
      end else if (a_inf || b_inf) begin
         sp_res_s = {sgn, 8'hFF, 23'd0};
      end else if (a_zero || b_zero) begin
         sp_res_s = {sgn, 31'd0};
      end else begin
         sp_res_s = 32'h0000_0000;
         sp_hit_s = 1'b0;
      end
   end

   // Normalise the finished product, round, and range-check the exponent.
   always_comb begin
`ifdef FPU_MUL_RNE_EN
      guard_s  = 1'b0;
      sticky_s = 1'b0;
      rnd_s    = 25'd0;
`endif
      if (prod_q[47]) begin
         norm_mant_s = prod_q[46:24];
         norm_exp_s  = exp_q + 10'sd1;
`ifdef FPU_MUL_RNE_EN
         guard_s     = prod_q[23];
         sticky_s    = |prod_q[22:0];
`endif
      end else begin
         norm_mant_s = prod_q[45:23];
         norm_exp_s  = exp_q;
`ifdef FPU_MUL_RNE_EN
         guard_s     = prod_q[22];
         sticky_s    = |prod_q[21:0];
`endif
      end
`ifdef FPU_MUL_RNE_EN
      rnd_s = {2'b01, norm_mant_s} + {24'd0, guard_s & (sticky_s | norm_mant_s[0])};
      if (rnd_s[24]) begin
         // 1.111..1 rounded up becomes 10.000..0: renormalise.
         fin_mant_s = rnd_s[23:1];
         fin_exp_s  = norm_exp_s + 10'sd1;
      end else begin
         fin_mant_s = rnd_s[22:0];
         fin_exp_s  = norm_exp_s;
      end
`else
      fin_mant_s = norm_mant_s;
      fin_exp_s  = norm_exp_s;
`endif
      if (fin_exp_s >= 10'sd255) begin
         norm_res_s = {sign_q, 8'hFF, 23'd0};
         norm_ovf_s = 1'b1;
      end else if (fin_exp_s <= 10'sd0) begin
         norm_res_s = {sign_q, 31'd0};
         norm_ovf_s = 1'b0;
      end else begin
         norm_res_s = {sign_q, fin_exp_s[7:0], fin_mant_s};
         norm_ovf_s = 1'b0;
      end
   end

   // Next-state and datapath control for IDLE -> MUL -> NORM -> DONE.
   always_comb begin
      state_d   = state_q;
      ma_d      = ma_q;
      mb_d      = mb_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      special_d = special_q;
      spres_d   = spres_q;
      spflags_d = spflags_q;
      result_d  = result_q;
      flags_d   = flags_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               ma_d   = {1'b1, SrcA[22:0]};
               mb_d   = {1'b1, SrcB[22:0]};
               sign_d = SrcA[31] ^ SrcB[31];
               exp_d  = $signed({2'b00, SrcA[30:23]}) + $signed({2'b00, SrcB[30:23]}) - 10'sd127;
               prod_d = 48'd0;
               cnt_d  = 5'd0;
               if (sp_hit_s) begin
                  special_d = 1'b1;
                  spres_d   = sp_res_s;
                  spflags_d = mk_flags(sp_res_s, 1'b0);
                  state_d   = S_DONE;
               end else begin
                  special_d = 1'b0;
                  state_d   = S_MUL;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            if (mb_q[cnt_q]) begin
               prod_d = prod_q + ({24'd0, ma_q} << cnt_q);
            end else begin
               prod_d = prod_q;
            end
            if (cnt_q == 5'd23) begin
               state_d = S_NORM;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_NORM: begin
            result_d = norm_res_s;
            flags_d  = mk_flags(norm_res_s, norm_ovf_s);
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            // Bypass results were staged in IDLE and are published here.
            if (special_q) begin
               result_d  = spres_q;
               flags_d   = spflags_q;
               done_d    = 1'b1;
               special_d = 1'b0;
            end else begin
               special_d = 1'b0;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ma_q      <= 24'd0;
         mb_q      <= 24'd0;
         sign_q    <= 1'b0;
         exp_q     <= 10'sd0;
         prod_q    <= 48'd0;
         cnt_q     <= 5'd0;
         special_q <= 1'b0;
         spres_q   <= 32'd0;
         spflags_q <= 4'd0;
         result_q  <= 32'd0;
         flags_q   <= 4'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ma_q      <= ma_d;
         mb_q      <= mb_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         prod_q    <= prod_d;
         cnt_q     <= cnt_d;
         special_q <= special_d;
         spres_q   <= spres_d;
         spflags_q <= spflags_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
         done_q    <= done_d;
      end
   end

   assign Result = result_q;
   assign Flags  = flags_q;
   assign Done   = done_q;
   assign Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_mul_seq.sv
// tb_fpu_mul_seq: directed vector table, hand-written multi-cycle sequences
// and random operands checked against a plain-arithmetic binary32 model.
module tb_fpu_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [31:0] Result;
   logic [3:0]  Flags;
   logic        Busy;
   logic        Done;

   int n_pass  = 0;
   int n_total = 0;

   fpu_mul_seq dut (
      .clk    (clk),
      .reset  (reset),
      .Start  (Start),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .Result (Result),
      .Flags  (Flags),
      .Busy   (Busy),
      .Done   (Done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flags;
      int          lat;
   } vec_t;

   vec_t tbl[$];

`ifdef FPU_MUL_RNE_EN
   localparam logic [31:0] RND_EXP = 32'h4010_0002;
`else
   localparam logic [31:0] RND_EXP = 32'h4010_0001;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference: value-level binary32 multiply with flush-to-zero.
   function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [3:0] f, output int lat);
      int     ea, eb, e, sh;
      longint fa, fb, p, m;
      logic   s, nan_a, nan_b, inf_a, inf_b, z_a, z_b;
      ea = a[30:23]; eb = b[30:23];
      fa = longint'(a[22:0]); fb = longint'(b[22:0]);
      s  = a[31] ^ b[31];
      nan_a = (ea == 255) && (fa != 0); nan_b = (eb == 255) && (fb != 0);
      inf_a = (ea == 255) && (fa == 0); inf_b = (eb == 255) && (fb == 0);
      z_a = (ea == 0); z_b = (eb == 0);
      lat = 1;
      if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) begin
         r = 32'h7FC0_0000; f = 4'b0000;
      end else if (inf_a || inf_b) begin
         r = {s, 8'hFF, 23'd0}; f = {s, 3'b000};
      end else if (z_a || z_b) begin
         r = {s, 31'd0}; f = {s, 3'b100};
      end else begin
         lat = 25;
         p = (fa + (longint'(1) << 23)) * (fb + (longint'(1) << 23));
         e = ea + eb - 127;
         if (p >= (longint'(1) << 47)) begin sh = 24; e = e + 1; end
         else sh = 23;
         m = p >> sh;
`ifdef FPU_MUL_RNE_EN
         begin
            longint rem, half;
            rem  = p - (m << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (m % 2) == 1)) begin
               m = m + 1;
               if (m == (longint'(1) << 24)) begin m = m >> 1; e = e + 1; end
            end
         end
`endif
         if (e >= 255) begin
            r = {s, 8'hFF, 23'd0}; f = {s, 3'b001};
         end else if (e <= 0) begin
            r = {s, 31'd0}; f = {s, 3'b100};
         end else begin
            r = {s, 8'(e), 23'(m)}; f = {s, 3'b000};
         end
      end
   endfunction

   function automatic logic [31:0] rnd_operand();
      logic [31:0] v;
      int          sel;
      v   = $urandom;
      sel = $urandom_range(0, 11);
      case (sel)
         0:       v[30:23] = 8'h00;
         1:       v[30:23] = 8'hFF;
         2:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
         3, 4:    v = v;
         default: v[30:23] = 8'($urandom_range(100, 154));
      endcase
      return v;
   endfunction

   // Launch one operation (caller sits just after an edge), wait for Done
   // with a bounded budget, and check the pulse/Busy behaviour after it.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
      SrcA = a; SrcB = b; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
      r = 32'hDEAD_BEEF; f = 4'hF; lat = -1;
      chk("busy_after_start", {31'd0, Busy}, 32'd1);
      if (Done) begin lat = 0; r = Result; f = Flags; end
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (Done) begin lat = k; r = Result; f = Flags; end
      end
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, Done}, 32'd0);
      chk("busy_idle_after", {31'd0, Busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] r, er;
      logic [3:0]  f, ef;
      int          lat, elat, done_seen;

      tbl.push_back('{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 25});
      tbl.push_back('{32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 4'b1000, 25});
      tbl.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0000, 1});
      tbl.push_back('{32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0100, 1});
      tbl.push_back('{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0001, 25});
      tbl.push_back('{32'h3FC0_0001, 32'h3FC0_0001, RND_EXP,       4'b0000, 25});
      tbl.push_back('{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'b1100, 1});
      tbl.push_back('{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000, 1});
      tbl.push_back('{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b1000, 1});
      tbl.push_back('{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0100, 1});
      tbl.push_back('{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0100, 25});
      tbl.push_back('{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 25});
      tbl.push_back('{32'hFF00_0000, 32'h4000_0000, 32'hFF80_0000, 4'b1001, 25});
      tbl.push_back('{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 4'b0000, 25});

      reset = 1'b1; Start = 1'b0; SrcA = 32'd0; SrcB = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result", Result, 32'd0);
      chk("reset_flags", {28'd0, Flags}, 32'd0);
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_done", {31'd0, Done}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed table, run back to back.
      foreach (tbl[i]) begin
         do_op(tbl[i].a, tbl[i].b, r, f, lat);
         chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
         chk($sformatf("tbl%0d_flags", i), {28'd0, f}, {28'd0, tbl[i].flags});
         chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      end

      // Start while busy must be ignored.
      SrcA = 32'h4000_0000; SrcB = 32'h4040_0000; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      lat = -1; r = 32'hDEAD_BEEF; f = 4'hF;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (k == 5) begin SrcA = 32'h3F80_0000; SrcB = 32'h3F80_0000; Start = 1'b1; end
         if (k == 6) Start = 1'b0;
         if (Done) begin lat = k; r = Result; f = Flags; end
      end
      chk("ignored_start_result", r, 32'h40C0_0000);
      chk("ignored_start_latency", lat, 32'd25);
      @(posedge clk); #1;
      do_op(32'h4080_0000, 32'h3F00_0000, r, f, lat);
      chk("after_ignored_result", r, 32'h4000_0000);
      chk("after_ignored_latency", lat, 32'd25);

      // Reset in the middle of an operation.
      SrcA = 32'h4000_0000; SrcB = 32'h4040_0000; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midreset_busy", {31'd0, Busy}, 32'd0);
      chk("midreset_result", Result, 32'd0);
      chk("midreset_flags", {28'd0, Flags}, 32'd0);
      chk("midreset_done", {31'd0, Done}, 32'd0);
      reset = 1'b0;
      done_seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (Done) done_seen++;
      end
      chk("midreset_no_done", done_seen, 32'd0);
      do_op(32'hBFC0_0000, 32'h4000_0000, r, f, lat);
      chk("post_reset_result", r, 32'hC040_0000);
      chk("post_reset_flags", {28'd0, f}, 32'h8);

      // Random operands against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a, b;
         a = rnd_operand();
         b = rnd_operand();
         ref_mul(a, b, er, ef, elat);
         do_op(a, b, r, f, lat);
         chk($sformatf("rnd%0d_result %h*%h", n, a, b), r, er);
         chk($sformatf("rnd%0d_flags %h*%h", n, a, b), {28'd0, f}, {28'd0, ef});
         chk($sformatf("rnd%0d_latency", n), lat, elat);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
